// File: rtl/decoder_pkg.sv
// decoder_pkg: shared types for the sweep decoder
package decoder_pkg;
  typedef enum logic {IDLE, SWEEP} sweep_state_t;
endpackage

// File: rtl/decoder_sweep_if.sv
// decoder_sweep_if: decode request / one-hot result bundle
interface decoder_sweep_if #(parameter int N = 3);
  localparam int W = 2**N;
  logic en;
  logic [N-1:0] in;
  logic sweep_start;
  logic [W-1:0] out;
  logic busy;
  logic sweep_done;
  modport master (output en, in, sweep_start, input out, busy, sweep_done);
  modport slave (input en, in, sweep_start, output out, busy, sweep_done);
endinterface

// File: rtl/decoder_n.sv
// decoder_n: combinational N-to-2^N one-hot decoder with enable
module decoder_n #(parameter int N = 3) (
  input  logic en,
  input  logic [N-1:0] sel,
  output logic [2**N-1:0] y
);
  localparam int W = 2**N;
  assign y = en ? {{(W-1){1'b0}}, 1'b1} << sel : '0;
endmodule

// File: rtl/decoder_sweep.sv
// decoder_sweep: registered one-hot decoder with a one-pass sweep of every output line
module decoder_sweep
  import decoder_pkg::*;
#(parameter int N = 3) (
  input logic clk,
  input logic reset,
  decoder_sweep_if.slave bus
);
  localparam int W = 2**N;
  sweep_state_t state, state_nx;
  logic [N:0] cnt, cnt_nx;
  logic [W-1:0] dec;
  logic act, busy_nx, done_nx;
  // cnt is 0 throughout IDLE, so a fresh start decodes cnt[N-1:0] = 0; cnt[N] marks cnt == W
  assign act = state == SWEEP || bus.sweep_start;
  decoder_n #(.N(N)) u_dec (
    .en(act ? !cnt[N] : bus.en),
    .sel(act ? cnt[N-1:0] : bus.in),
    .y(dec)
  );
  always_comb begin
    busy_nx = act && !cnt[N];
    done_nx = state == SWEEP && cnt[N];
    cnt_nx = busy_nx ? cnt + 1'b1 : '0;
    state_nx = busy_nx ? SWEEP : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      bus.out <= '0;
      bus.busy <= 1'b0;
      bus.sweep_done <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      bus.out <= dec;
      bus.busy <= busy_nx;
      bus.sweep_done <= done_nx;
    end
  end
endmodule

// File: tb/tb_decoder_sweep.sv
// tb_decoder_sweep: directed vector table plus sweep corner sequences for N=3 and N=5
module tb_decoder_sweep;
  logic clk = 0;
  logic reset;
  int n_cmp = 0;
  int n_err = 0;
  decoder_sweep_if #(.N(3)) bus3 ();
  decoder_sweep_if #(.N(5)) bus5 ();
  decoder_sweep #(.N(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));
  decoder_sweep #(.N(5)) dut5 (.clk(clk), .reset(reset), .bus(bus5));
  always #5 clk = ~clk;

  typedef struct {
    logic en;
    logic [2:0] in;
    logic start;
    logic [7:0] out;
    logic busy;
    logic done;
  } vec_t;
  vec_t tbl[19];
  logic [7:0] hot[8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string name, input logic [7:0] o, input logic b, input logic d);
    chk({name, ".out"}, 32'(bus3.out), 32'(o));
    chk({name, ".busy"}, 32'(bus3.busy), 32'(b));
    chk({name, ".done"}, 32'(bus3.sweep_done), 32'(d));
  endtask

  always @(negedge clk) begin
    n_cmp++;
    if ($countones(bus3.out) > 1 || $countones(bus5.out) > 1) begin
      n_err++;
      $display("FAIL onehot: out3 %h out5 %h has more than one line high", bus3.out, bus5.out);
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) tbl[i] = '{1'b1, 3'(i), 1'b0, hot[i], 1'b0, 1'b0};
    tbl[8] = '{1'b0, 3'd5, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[9] = '{1'b1, 3'd3, 1'b1, 8'h01, 1'b1, 1'b0};
    for (int i = 1; i < 8; i++) tbl[9+i] = '{1'b1, 3'd3, 1'b0, hot[i], 1'b1, 1'b0};
    tbl[17] = '{1'b1, 3'd3, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[18] = '{1'b1, 3'd3, 1'b0, 8'h08, 1'b0, 1'b0};

    reset = 1;
    bus3.en = 0; bus3.in = 0; bus3.sweep_start = 0;
    bus5.en = 0; bus5.in = 0; bus5.sweep_start = 0;
    step();
    step();
    chk3("reset", 8'h00, 1'b0, 1'b0);
    reset = 0;

    for (int v = 0; v < 19; v++) begin
      bus3.en = tbl[v].en;
      bus3.in = tbl[v].in;
      bus3.sweep_start = tbl[v].start;
      step();
      chk3($sformatf("vec%0d", v), tbl[v].out, tbl[v].busy, tbl[v].done);
    end

    bus3.sweep_start = 1;
    step();
    chk3("ign0", 8'h01, 1'b1, 1'b0);
    for (int i = 1; i < 8; i++) begin
      bus3.en = 1'($urandom);
      bus3.in = 3'($urandom);
      bus3.sweep_start = 1'(i % 2);
      step();
      chk3($sformatf("ign%0d", i), hot[i], 1'b1, 1'b0);
    end
    bus3.sweep_start = 1;
    step();
    chk3("ign_done", 8'h00, 1'b0, 1'b1);
    bus3.sweep_start = 0;
    bus3.en = 1;
    bus3.in = 2;
    step();
    chk3("ign_after", 8'h04, 1'b0, 1'b0);
    step();
    chk3("ign_after2", 8'h04, 1'b0, 1'b0);

    bus3.sweep_start = 1;
    step();
    bus3.sweep_start = 0;
    repeat (4) step();
    chk3("mid_pre", 8'h10, 1'b1, 1'b0);
    reset = 1;
    step();
    chk3("mid_rst", 8'h00, 1'b0, 1'b0);
    reset = 0;
    bus3.in = 6;
    step();
    chk3("mid_dec", 8'h40, 1'b0, 1'b0);
    step();
    chk3("mid_dec2", 8'h40, 1'b0, 1'b0);

    reset = 1;
    step();
    reset = 0;
    bus5.sweep_start = 1;
    for (int p = 0; p < 33 * 2 + 5; p++) begin
      int ph;
      ph = p % 33;
      step();
      chk($sformatf("n5_out%0d", p), bus5.out, ph < 32 ? 32'd1 << ph : 32'd0);
      chk($sformatf("n5_busy%0d", p), 32'(bus5.busy), ph < 32 ? 32'd1 : 32'd0);
      chk($sformatf("n5_done%0d", p), 32'(bus5.sweep_done), ph == 32 ? 32'd1 : 32'd0);
    end
    bus5.sweep_start = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
